// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM state type, seven-segment patterns (active-low gfedcba) and BCD add-3 helper
package calc_pkg;
  typedef enum logic {IDLE, CONVERT} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  function automatic logic [11:0] add3(input logic [11:0] s);
    for (int i = 0; i < 3; i++)
      add3[4*i+:4] = s[4*i+:4] >= 4'd5 ? s[4*i+:4] + 4'd3 : s[4*i+:4];
  endfunction
endpackage

// File: rtl/result_display_if.sv
// result_display_if: load/value in, busy/bcd status and an/seg/dp display drive; master=producer, slave=display
interface result_display_if;
  logic        load;
  logic [7:0]  value;
  logic        busy;
  logic [11:0] bcd;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  modport master(output load, value, input busy, bcd, an, seg, dp);
  modport slave(input load, value, output busy, bcd, an, seg, dp);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 8-cycle double-dabble converter; ports clk, rst, load, value[7:0] in; busy, bcd[11:0] out
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  value,
  output logic        busy,
  output logic [11:0] bcd
);
  state_t state;
  logic [7:0] sh;
  logic [11:0] sc;
  logic [2:0] cnt;
  logic [19:0] nx;
  always_comb nx = {add3(sc), sh} << 1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      sc <= '0;
      cnt <= '0;
      busy <= 1'b0;
      bcd <= '0;
    end else if (state == IDLE) begin
      if (load) begin
        sh <= value;
        sc <= '0;
        cnt <= '0;
        busy <= 1'b1;
        state <= CONVERT;
      end
    end else begin
      sc <= nx[19:8];
      sh <= nx[7:0];
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) begin
        bcd <= nx[19:8];
        busy <= 1'b0;
        state <= IDLE;
      end
    end
endmodule

// File: rtl/result_display.sv
// result_display: binary->BCD plus 4-digit multiplexed 7-seg drive; ports clk, rst, bus (load/value in; busy/bcd/an/seg/dp out)
module result_display
  import calc_pkg::*;
#(
  parameter int REFRESH_BITS = 16
) (
  input logic clk,
  input logic rst,
  result_display_if.slave bus
);
  logic [REFRESH_BITS-1:0] cnt;
  logic [1:0] idx;
  logic [3:0] dig;
  logic blank;
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = SEG_0;
      4'd1: seg_of = SEG_1;
      4'd2: seg_of = SEG_2;
      4'd3: seg_of = SEG_3;
      4'd4: seg_of = SEG_4;
      4'd5: seg_of = SEG_5;
      4'd6: seg_of = SEG_6;
      4'd7: seg_of = SEG_7;
      4'd8: seg_of = SEG_8;
      4'd9: seg_of = SEG_9;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction
  bin2bcd_seq u_conv (
    .clk(clk),
    .rst(rst),
    .load(bus.load),
    .value(bus.value),
    .busy(bus.busy),
    .bcd(bus.bcd)
  );
  always_comb begin
    dig = idx == 2'd0 ? bus.bcd[3:0] : idx == 2'd1 ? bus.bcd[7:4] : bus.bcd[11:8];
    blank = idx == 2'd3 || (idx == 2'd2 && bus.bcd[11:8] == 4'd0) || (idx == 2'd1 && bus.bcd[11:4] == 8'd0);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      bus.an <= 4'b1111;
      bus.seg <= SEG_BLANK;
    end else begin
      cnt <= cnt + 1'b1;
      if (&cnt) idx <= idx + 2'd1;
      bus.an <= ~(4'b0001 << idx);
      bus.seg <= blank ? SEG_BLANK : seg_of(dig);
    end
  assign bus.dp = 1'b1;
endmodule

// File: tb/tb_result_display.sv
// tb_result_display: table-driven directed check of conversion, latency, blanking and scan, plus reset/load corner sequences
module tb_result_display;
  logic clk = 0, rst = 1;
  int vec = 0, bad = 0;
  result_display_if bus ();
  result_display #(.REFRESH_BITS(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0]  v;
    logic [11:0] b;
    logic [6:0]  s [4];
  } vec_t;
  vec_t tbl [8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 30) begin
      step();
      n++;
    end
    if (bus.busy) chk("idle_timeout", 1, 0);
  endtask
  task automatic do_load(input logic [7:0] v, output int n);
    wait_idle();
    bus.value = v;
    bus.load = 1;
    step();
    bus.load = 0;
    n = 0;
    while (bus.busy && n < 30) begin
      n++;
      step();
    end
  endtask
  task automatic check_display(input string nm, input logic [6:0] e [4]);
    logic [3:0] seen = 0;
    int k;
    for (int i = 0; i < 20; i++) begin
      step();
      k = bus.an == 4'b1110 ? 0 : bus.an == 4'b1101 ? 1 : bus.an == 4'b1011 ? 2 : bus.an == 4'b0111 ? 3 : -1;
      if (k < 0) chk({nm, "_an"}, {28'd0, bus.an}, 4'b1110);
      else begin
        seen[k] = 1'b1;
        chk($sformatf("%s_seg%0d", nm, k), {25'd0, bus.seg}, {25'd0, e[k]});
      end
    end
    chk({nm, "_scan"}, {28'd0, seen}, 4'hf);
  endtask
  initial begin
    int n;
    logic [6:0] bl = 7'b1111111;
    tbl[0] = '{8'd225, 12'h225, '{7'b0010010, 7'b0100100, 7'b0100100, bl}};
    tbl[1] = '{8'd7,   12'h007, '{7'b1111000, bl, bl, bl}};
    tbl[2] = '{8'd100, 12'h100, '{7'b1000000, 7'b1000000, 7'b1111001, bl}};
    tbl[3] = '{8'd0,   12'h000, '{7'b1000000, bl, bl, bl}};
    tbl[4] = '{8'd255, 12'h255, '{7'b0010010, 7'b0010010, 7'b0100100, bl}};
    tbl[5] = '{8'd42,  12'h042, '{7'b0100100, 7'b0011001, bl, bl}};
    tbl[6] = '{8'd10,  12'h010, '{7'b1000000, 7'b1111001, bl, bl}};
    tbl[7] = '{8'd99,  12'h099, '{7'b0010000, 7'b0010000, bl, bl}};
    bus.load = 0;
    bus.value = 0;
    repeat (2) step();
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_bcd", {20'd0, bus.bcd}, 0);
    chk("rst_an", {28'd0, bus.an}, 4'b1111);
    chk("rst_seg", {25'd0, bus.seg}, 7'h7f);
    chk("rst_dp", {31'd0, bus.dp}, 1);
    rst = 0;
    check_display("scan0", '{7'b1000000, bl, bl, bl});
    for (int i = 0; i < 8; i++) begin
      do_load(tbl[i].v, n);
      chk($sformatf("busy_len_%0d", tbl[i].v), n, 8);
      chk($sformatf("bcd_%0d", tbl[i].v), {20'd0, bus.bcd}, {20'd0, tbl[i].b});
      check_display($sformatf("disp_%0d", tbl[i].v), tbl[i].s);
    end
    bus.value = 200;
    bus.load = 1;
    step();
    bus.load = 0;
    repeat (2) step();
    bus.value = 9;
    bus.load = 1;
    step();
    bus.load = 0;
    n = 0;
    while (bus.busy && n < 30) begin
      n++;
      step();
    end
    chk("ignored_load_rem", n, 5);
    chk("ignored_load_bcd", {20'd0, bus.bcd}, 12'h200);
    bus.value = 50;
    bus.load = 1;
    step();
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("held_busy_%0d", k), {31'd0, bus.busy}, k == 8 || k == 17 ? 0 : 1);
      step();
    end
    bus.load = 0;
    wait_idle();
    chk("held_bcd", {20'd0, bus.bcd}, 12'h050);
    bus.value = 255;
    bus.load = 1;
    step();
    bus.load = 0;
    repeat (4) step();
    rst = 1;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 0);
    chk("mid_rst_bcd", {20'd0, bus.bcd}, 0);
    chk("mid_rst_an", {28'd0, bus.an}, 4'b1111);
    chk("mid_rst_seg", {25'd0, bus.seg}, 7'h7f);
    step();
    rst = 0;
    do_load(8'd42, n);
    chk("post_rst_busy_len", n, 8);
    chk("post_rst_bcd", {20'd0, bus.bcd}, 12'h042);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/result_display.md
# result_display

Downstream stage of the calculator datapath. Captures the 8-bit unsigned result from the 4x4 multiplier (or any other 8-bit calculator stage), converts it to three BCD digits with an iterative shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto the Basys2 4-digit common-anode seven-segment display with leading-zero blanking.

## Interface
Parameters:
- REFRESH_BITS, 16, width of the free-running refresh counter; the digit advances on each counter wrap (about 763 Hz per digit at 50 MHz).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- load  in  1  single-cycle strobe; samples `value`. Honoured only when `busy`=0.
- value  in  8  unsigned binary result to display (0..255).
- busy  out  1  high while a conversion is in progress.
- bcd  out  12  displayed value: [11:8] hundreds, [7:4] tens, [3:0] ones.
- an  out  4  digit anodes, active-low; an[0] is the rightmost (ones) digit.
- seg  out  7  segments gfedcba, active-low; seg[0]=a.
- dp  out  1  decimal point, active-low; constant 1 (off).

## Operation
- FSM states: IDLE, CONVERT.
- IDLE: if load=1, capture value into the binary shift register, clear the BCD scratch register, clear the 3-bit iteration count, and go to CONVERT.
- CONVERT, each cycle: every BCD scratch nibble >=5 gets +3, then {scratch, shift} shifts left by 1, count increments. On the 8th iteration (count=7), the post-shift scratch value is written to `bcd`, and the FSM returns to IDLE.
- load is ignored in CONVERT: no queueing, and the captured value is unchanged.
- `bcd` changes only at the end of a conversion, so the display never shows partial digits.
- Width rules: 8-bit input; 12-bit scratch register. The hundreds digit is at most 2.
- Display mux: a 2-bit digit index selects digit 0 (ones), 1 (tens), 2 (hundreds), or 3.
- Digit 3 is always blank: an[3] is driven low in its slot, but seg=7'b1111111.
- Leading-zero blanking: hundreds is blank if it is 0. Tens is blank if hundreds and tens are both 0. Ones is never blank.
- Decoder (seg, active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Non-BCD codes and blanked digits give 1111111.

## Timing
- Reset values: busy=0, bcd=12'h000, an=4'b1111, seg=7'b1111111, dp=1, FSM=IDLE, refresh counter=0, digit index=0.
- The first refresh wrap after reset shows "0" on digit 0.
- Conversion timing:
  - load is sampled high at edge N.
  - busy=1 after edge N.
  - Iterations occur at edges N+1..N+8.
  - `bcd` is valid and busy=0 after edge N+8.
  - Latency is 8 cycles from the load edge.
  - The earliest accepted next load is sampled at edge N+9.
- load held high continuously: a new conversion starts on every edge where the FSM is IDLE (every 9 cycles).
- Refresh:
  - The counter is free-running and is not affected by load.
  - When the counter is all-ones, the digit index increments and wraps 3->0.
  - an/seg are registered and reflect the new index one cycle later.
- Reset asserted mid-conversion: everything returns to reset values immediately (asynchronous). The old `bcd` is lost. No partial result is written.

## Structure
- Shared package `calc_pkg`:
  - state enum {IDLE, CONVERT};
  - SEG_BLANK constant (7'b1111111);
  - the ten digit-pattern constants.
- Sub-module `bin2bcd_seq`: the FSM, shift/add-3 datapath, and `busy`/`bcd` outputs.
- The top level `result_display` holds the refresh counter, digit mux, blanking logic, and segment decoder (a function using the `calc_pkg` constants).

## Test plan
- Reset then release with REFRESH_BITS=2 -> `bcd`=000, busy=0. The scan cycles an 1110, 1101, 1011, 0111, with seg 1000000 only on an=1110 and 1111111 otherwise.
- load value=225 (15x15) at edge N -> busy high for exactly 8 cycles, then `bcd`=12'h225. Digits read 2, 2, 5, with digit 3 blank.
- load value=7 -> `bcd`=12'h007. Hundreds and tens are blanked (seg 1111111); ones shows 1111000.
- load value=100 -> `bcd`=12'h100. Tens shows 1000000 (not blanked, since hundreds is nonzero).
- load 200, then load 9 pulsed 3 cycles later -> the second load is ignored, and `bcd`=12'h200 after 8 cycles.
- load 255, then assert rst at cycle 4 of the conversion -> `bcd`=000, busy=0, an=1111 immediately. After release, load 42 -> `bcd`=12'h042.
